// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: 2-flop synchroniser, stability-window debounce,
// press/release pulses. Define BTN_DEBOUNCE_REPEAT_EN to build the auto-repeat generator.
module btn_debounce_multi #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 100000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_RATE   = 10000000,
   parameter int CNT_W         = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release,
   output logic [CHANNELS-1:0] btn_repeat
);

   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic             s1_reg;
         logic             s2_reg;
         logic             level_reg;
         logic             press_reg;
         logic             release_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             accept;

         // The window completes on the edge where the mismatch has lasted STABLE_CYCLES edges.
         assign accept = (s2_reg != level_reg) && (cnt_reg == STABLE_MAX);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg      <= 1'b0;
               s2_reg      <= 1'b0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               cnt_reg     <= CNT_ZERO;
            end else begin
               s1_reg      <= button[gi];
               s2_reg      <= s1_reg;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               if (s2_reg == level_reg) begin
                  cnt_reg <= CNT_ZERO;
               end else if (accept) begin
                  level_reg   <= s2_reg;
                  cnt_reg     <= CNT_ZERO;
                  press_reg   <= s2_reg;
                  release_reg <= ~s2_reg;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
         end

         assign btn_level[gi]   = level_reg;
         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = release_reg;

`ifdef BTN_DEBOUNCE_REPEAT_EN
         localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(REPEAT_DELAY - 1);
         localparam logic [CNT_W-1:0] RATE_MAX  = CNT_W'(REPEAT_RATE - 1);

         logic [CNT_W-1:0] rcnt_reg;
         logic             rph_reg;
         logic             repeat_reg;

         // Clearing on any accept keeps repeat pulses out of press and release cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rcnt_reg   <= CNT_ZERO;
               rph_reg    <= 1'b0;
               repeat_reg <= 1'b0;
            end else begin
               repeat_reg <= 1'b0;
               if (accept || !level_reg) begin
                  rcnt_reg <= CNT_ZERO;
                  rph_reg  <= 1'b0;
               end else if (!rph_reg && (rcnt_reg == DELAY_MAX)) begin
                  repeat_reg <= 1'b1;
                  rcnt_reg   <= CNT_ZERO;
                  rph_reg    <= 1'b1;
               end else if (rph_reg && (rcnt_reg == RATE_MAX)) begin
                  repeat_reg <= 1'b1;
                  rcnt_reg   <= CNT_ZERO;
               end else begin
                  rcnt_reg <= rcnt_reg + CNT_ONE;
               end
            end
         end

         assign btn_repeat[gi] = repeat_reg;
`else
         assign btn_repeat[gi] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed vector table, hand sequences for repeat and
// mid-window reset, then random stimulus against a behavioural model.
module tb_btn_debounce_multi;

   localparam int CH = 2;
   localparam int S  = 4;
   localparam int D  = 10;
   localparam int R  = 3;
`ifdef BTN_DEBOUNCE_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] button;
   logic [CH-1:0] btn_level;
   logic [CH-1:0] btn_press;
   logic [CH-1:0] btn_release;
   logic [CH-1:0] btn_repeat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   btn_debounce_multi #(
      .CHANNELS(CH), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .button(button), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   // Behavioural model: a level flips once S consecutive synchronised samples disagree
   // with it; repeats fire D edges after the press and every R edges thereafter.
   logic [CH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
   int            m_streak [CH];
   int            m_held   [CH];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
      for (int c = 0; c < CH; c++) begin
         m_streak[c] = 0;
         m_held[c]   = 0;
      end
   endtask

   task automatic model_edge(input logic [CH-1:0] b);
      for (int c = 0; c < CH; c++) begin
         m_press[c] = 1'b0;
         m_rel[c]   = 1'b0;
         m_rep[c]   = 1'b0;
         m_streak[c] = (m_s2[c] != m_level[c]) ? m_streak[c] + 1 : 0;
         if (m_streak[c] == S) begin
            m_streak[c] = 0;
            m_level[c]  = m_s2[c];
            if (m_s2[c]) begin
               m_press[c] = 1'b1;
               m_held[c]  = 0;
            end else begin
               m_rel[c] = 1'b1;
            end
         end else if (m_level[c]) begin
            m_held[c]++;
            if (REP_EN && (m_held[c] == D || (m_held[c] > D && (m_held[c] - D) % R == 0)))
               m_rep[c] = 1'b1;
         end
      end
      m_s2 = m_s1;
      m_s1 = b;
   endtask

   task automatic step(input logic [CH-1:0] b);
      button = b;
      @(posedge clk);
      if (rst_n) model_edge(b);
      #1;
   endtask

   task automatic check(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [CH-1:0] lvl, input logic [CH-1:0] prs,
                            input logic [CH-1:0] rel, input logic [CH-1:0] rep);
      check({tag, ".level"},   btn_level,   lvl);
      check({tag, ".press"},   btn_press,   prs);
      check({tag, ".release"}, btn_release, rel);
      check({tag, ".repeat"},  btn_repeat,  rep);
   endtask

   typedef struct {
      logic [CH-1:0] b;
      logic [CH-1:0] lvl;
      logic [CH-1:0] prs;
      logic [CH-1:0] rel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [CH-1:0] b, input logic [CH-1:0] lvl,
                      input logic [CH-1:0] prs, input logic [CH-1:0] rel, input int n);
      vec_t v;
      v.b = b; v.lvl = lvl; v.prs = prs; v.rel = rel;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      logic [CH-1:0] cur;
      logic [CH-1:0] e_rep;

      // Reset held with both buttons high.
      rst_n  = 1'b0;
      button = 2'b11;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(2'b11);
         check_all("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
         $display("reset edge %0d level=%b press=%b", i, btn_level, btn_press);
      end
      rst_n = 1'b1;

      // Each entry is one edge: input applied before it, outputs expected after it.
      add(2'b11, 2'b00, 2'b00, 2'b00, 5); add(2'b11, 2'b11, 2'b11, 2'b00, 1); add(2'b11, 2'b11, 2'b00, 2'b00, 1);
      add(2'b00, 2'b11, 2'b00, 2'b00, 5); add(2'b00, 2'b00, 2'b00, 2'b11, 1); add(2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(2'b01, 2'b00, 2'b00, 2'b00, 5); add(2'b01, 2'b01, 2'b01, 2'b00, 1); add(2'b01, 2'b01, 2'b00, 2'b00, 1);
      add(2'b00, 2'b01, 2'b00, 2'b00, 5); add(2'b00, 2'b00, 2'b00, 2'b01, 1); add(2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(2'b01, 2'b00, 2'b00, 2'b00, 3); add(2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(2'b01, 2'b00, 2'b00, 2'b00, 5); add(2'b01, 2'b01, 2'b01, 2'b00, 1); add(2'b01, 2'b01, 2'b00, 2'b00, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].b);
         check_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, 2'b00);
         $display("vec %0d btn=%b level=%b press=%b release=%b", i, tbl[i].b, btn_level, btn_press, btn_release);
      end

      // Held ch0: the last table entry was edge P+1 after the press at edge P.
      for (int k = 2; k <= 21; k++) begin
         step(2'b01);
         e_rep = (REP_EN && (k == 10 || k == 13 || k == 16 || k == 19)) ? 2'b01 : 2'b00;
         check_all($sformatf("hold_p%0d", k), 2'b01, 2'b00, 2'b00, e_rep);
         $display("hold P+%0d repeat=%b", k, btn_repeat);
      end
      // Release: edges P+22.. ; repeats continue until the level drops.
      for (int j = 0; j < 8; j++) begin
         step(2'b00);
         e_rep = (REP_EN && j < 5 && ((12 + j) % R == 0)) ? 2'b01 : 2'b00;
         check_all($sformatf("rel_e%0d", j), (j < 5) ? 2'b01 : 2'b00, 2'b00,
                   (j == 5) ? 2'b01 : 2'b00, e_rep);
         $display("release E%0d level=%b release=%b repeat=%b", j, btn_level, btn_release, btn_repeat);
      end

      // Reset in the middle of a ch0 window while ch1 is already accepted.
      for (int i = 0; i < 7; i++) step(2'b10);
      check_all("ch1_up", 2'b10, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 4; i++) step(2'b11);
      check_all("window_cnt2", 2'b10, 2'b00, 2'b00, 2'b00);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
      $display("async reset level=%b", btn_level);
      for (int i = 0; i < 2; i++) begin
         step(2'b11);
         check_all("rst_low", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step(2'b11);
         check_all($sformatf("reaccept_e%0d", k), (k >= 5) ? 2'b11 : 2'b00,
                   (k == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00);
         $display("re-accept E%0d level=%b press=%b", k, btn_level, btn_press);
      end

      // Random phase against the model, starting from a fresh reset.
      rst_n = 1'b0;
      model_reset();
      cur = 2'b00;
      step(cur);
      step(cur);
      rst_n = 1'b1;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, (i < 400) ? 5 : 40) == 0) cur[c] = ~cur[c];
         step(cur);
         check_all($sformatf("rnd%0d", i), m_level, m_press, m_rel, m_rep);
         if (i % 100 == 99)
            $display("random cycle %0d level=%b model=%b bad=%0d", i, btn_level, m_level, bad);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner sitting between the board's raw button/switch pins and the CPU-side input logic. Each channel synchronises its asynchronous input into `clk`, debounces it with a configurable stability window, and produces a clean level plus single-cycle press/release pulses. An optional auto-repeat generator emits periodic pulses while a button is held.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent button channels.
- `STABLE_CYCLES`, 100000: consecutive mismatching cycles required to accept a new level; must be ≥1.
- `REPEAT_DELAY`, 50000000: cycles from press pulse to first repeat pulse; ≥1; used only with the repeat macro.
- `REPEAT_RATE`, 10000000: cycles between subsequent repeat pulses; ≥1; used only with the repeat macro.
- `CNT_W`, 32: width of every internal counter; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_RATE)-1.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button`  in  CHANNELS  raw asynchronous inputs, active-high.
- `btn_level`  out  CHANNELS  debounced level.
- `btn_press`  out  CHANNELS  one-cycle pulse on accepted 0→1.
- `btn_release`  out  CHANNELS  one-cycle pulse on accepted 1→0.
- `btn_repeat`  out  CHANNELS  one-cycle auto-repeat pulse; constant 0 when feature compiled out.

## Operation
- Channels fully independent; identical per-channel logic.
- Synchroniser: two flops, `s1 <= button[i]`, `s2 <= s1`.
- Debounce counter `cnt`:
  - `s2 == btn_level[i]`: `cnt <= 0` (any bounce back restarts the window).
  - `s2 != btn_level[i]` and `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != btn_level[i]` and `cnt == STABLE_CYCLES-1`: `btn_level[i] <= s2`, `cnt <= 0`, assert `btn_press[i]` (if s2=1) or `btn_release[i]` (if s2=0) for exactly that one cycle.
- Pulse outputs are registered; default 0 every cycle unless set by above rule.
- Press and release never coincide on one channel; different channels may pulse in the same cycle.
- Repeat generator (macro enabled), counter `rcnt`, phase bit `rph` (0=delay, 1=rate):
  - press pulse cycle or `btn_level[i]==0`: `rcnt <= 0`, `rph <= 0`.
  - level 1, `rph==0`, `rcnt == REPEAT_DELAY-1`: pulse `btn_repeat[i]`, `rcnt <= 0`, `rph <= 1`.
  - level 1, `rph==1`, `rcnt == REPEAT_RATE-1`: pulse `btn_repeat[i]`, `rcnt <= 0`.
  - otherwise level 1: `rcnt <= rcnt+1`.
  - Repeat never fires in a press or release cycle.

## Timing
- Reset values (async, immediate on `rst_n`=0): `s1`, `s2`, `cnt`, `rcnt`, `rph`, `btn_level`, `btn_press`, `btn_release`, `btn_repeat` all 0.
- Reset mid-window or mid-repeat: all state cleared, no pulse emitted; after release, a still-held button is re-accepted as a fresh press after the full latency.
- Input held high through reset: press pulse after the normal latency.
- Latency: `button[i]` changes before edge E0 and stays stable → `s2` new after E1 → `btn_level` change and pulse visible after edge E0+STABLE_CYCLES+1.
- Mismatch shorter than STABLE_CYCLES cycles (measured at `s2`): no output change.
- First repeat visible after edge P+REPEAT_DELAY (P = edge asserting press); then every REPEAT_RATE cycles while held.
- No wrap-around: counters compare-and-clear before reaching max.

## Configuration
- `BTN_DEBOUNCE_REPEAT_EN` defined: repeat generator built, `btn_repeat` behaves as above.
- Undefined: no `rcnt`/`rph` logic, `btn_repeat` tied to 0; all other behaviour identical.

## Test plan
Bench: CHANNELS=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, macro defined.
- Reset: hold `rst_n`=0 with `button`=2'b11 → all outputs 0; release reset → `btn_press`=2'b11 one cycle after edge 5, `btn_level`=2'b11 thereafter.
- Clean press ch0 before E0 → `btn_level[0]`=1 and `btn_press[0]`=1 after E5, `btn_press[0]`=0 after E6; ch1 unchanged.
- Bounce: ch0 high 3 cycles, low 1, high steady → no pulse during glitch; press appears 5 cycles after the final rising sample edge.
- Hold ch0 after press at edge P → `btn_repeat[0]` pulses after P+10, P+13, P+16; release → `btn_release[0]` pulse after latency, no further repeats.
- Assert `rst_n`=0 at cnt=2 of a press window → outputs 0 immediately, no press pulse; with macro undefined, holding 30 cycles gives `btn_repeat`=0 throughout.
